// File: rtl/kmap_scan_checker.sv
// kmap_scan_checker: sweeps every input vector of a small combinational function, records its truth table and counts mismatches against an expected map.
// Optional first-mismatch capture is enabled by defining KMAP_SCAN_FIRST_ERR_EN.
module kmap_scan_checker #(
    parameter int NVARS  = 3,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    start_i,
    input  logic [(1<<NVARS)-1:0]   expected_i,
    output logic [NVARS-1:0]        vec_o,
    input  logic                    dut_out_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [(1<<NVARS)-1:0]   table_o,
    output logic [NVARS:0]          mismatch_cnt_o,
    output logic                    pass_o
`ifdef KMAP_SCAN_FIRST_ERR_EN
    ,
    output logic [NVARS-1:0]        first_err_idx_o,
    output logic                    first_err_valid_o
`endif
);
    localparam int N = 1 << NVARS;
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [NVARS-1:0] vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [N-1:0]     table_q, table_d;
    logic [NVARS:0]   mis_q, mis_d, mis_inc;
    logic             pass_q, pass_d;
    logic             miss;
`ifdef KMAP_SCAN_FIRST_ERR_EN
    logic [NVARS-1:0] ferr_idx_q, ferr_idx_d;
    logic             ferr_val_q, ferr_val_d;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        table_d = table_q;
        mis_d   = mis_q;
        pass_d  = pass_q;
        miss    = dut_out_i != expected_i[vec_q];
        mis_inc = mis_q + {{NVARS{1'b0}}, miss};
`ifdef KMAP_SCAN_FIRST_ERR_EN
        ferr_idx_d = ferr_idx_q;
        ferr_val_d = ferr_val_q;
`endif
        if (state_q == IDLE) begin
            // the done cycle itself refuses a start so scans never overlap a result pulse
            if (start_i && !done_q) begin
                state_d = SCAN;
                vec_d   = '0;
                cnt_d   = RELOAD;
                table_d = '0;
                mis_d   = '0;
                pass_d  = 1'b0;
`ifdef KMAP_SCAN_FIRST_ERR_EN
                ferr_idx_d = '0;
                ferr_val_d = 1'b0;
`endif
            end
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            table_d[vec_q] = dut_out_i;
            mis_d          = mis_inc;
`ifdef KMAP_SCAN_FIRST_ERR_EN
            if (miss && !ferr_val_q) begin
                ferr_idx_d = vec_q;
                ferr_val_d = 1'b1;
            end
`endif
            if (&vec_q) begin
                state_d = IDLE;
                vec_d   = '0;
                done_d  = 1'b1;
                pass_d  = mis_inc == '0;
            end else begin
                vec_d = vec_q + 1'b1;
                cnt_d = RELOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            table_q <= '0;
            mis_q   <= '0;
            pass_q  <= 1'b0;
`ifdef KMAP_SCAN_FIRST_ERR_EN
            ferr_idx_q <= '0;
            ferr_val_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            table_q <= table_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
`ifdef KMAP_SCAN_FIRST_ERR_EN
            ferr_idx_q <= ferr_idx_d;
            ferr_val_q <= ferr_val_d;
`endif
        end
    end

    assign vec_o          = vec_q;
    assign busy_o         = state_q == SCAN;
    assign done_o         = done_q;
    assign table_o        = table_q;
    assign mismatch_cnt_o = mis_q;
    assign pass_o         = pass_q;
`ifdef KMAP_SCAN_FIRST_ERR_EN
    assign first_err_idx_o   = ferr_idx_q;
    assign first_err_valid_o = ferr_val_q;
`endif

endmodule
